// File: rtl/gin_xbus_fifo.sv
// gin_xbus_fifo: tag-routed crossbar input stage with one small FIFO per
// destination column. An input word is pushed atomically into every column
// whose col_id equals its col_tag; words that match no column are dropped
// and counted in a saturating counter.
// Handshake: a transfer happens on a rising edge where valid (enable_in /
// enable_out[i]) and ready (ready_out / ready_in[i]) are both high; valid
// never waits on ready, and ready_out is derived only from registered FIFO
// occupancy, never from the same-cycle ready_in.
// Optional feature: define GIN_XBUS_BCAST_EN to make the all-ones tag a
// broadcast that matches every column.
module gin_xbus_fifo #(
  parameter int DATA_WIDTH     = 64,
  parameter int COL_TAG_WIDTH  = 4,
  parameter int NUM_OF_COLS    = 14,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COL_TAG_WIDTH-1:0]  col_tag,
  input  logic [COL_TAG_WIDTH-1:0]  col_id [0:NUM_OF_COLS-1],
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      enable_in,
  output logic                      ready_out,
  output logic [DATA_WIDTH-1:0]     data_out [0:NUM_OF_COLS-1],
  output logic [0:NUM_OF_COLS-1]    enable_out,
  input  logic [0:NUM_OF_COLS-1]    ready_in,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]     mem_q      [NUM_OF_COLS][FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q   [NUM_OF_COLS];
  logic [PW-1:0]             wr_ptr_d   [NUM_OF_COLS];
  logic [PW-1:0]             rd_ptr_q   [NUM_OF_COLS];
  logic [PW-1:0]             rd_ptr_d   [NUM_OF_COLS];
  logic [CW-1:0]             count_q    [NUM_OF_COLS];
  logic [CW-1:0]             count_d    [NUM_OF_COLS];
  logic [DROP_CNT_WIDTH-1:0] drop_count_q;
  logic [DROP_CNT_WIDTH-1:0] drop_count_d;
  logic [NUM_OF_COLS-1:0]    match;
  logic [NUM_OF_COLS-1:0]    push;
  logic [NUM_OF_COLS-1:0]    pop;
  logic                      accept;
  logic                      bcast;

  // Column match decode, with optional all-ones broadcast.
  always_comb begin
`ifdef GIN_XBUS_BCAST_EN
    bcast = &col_tag;
`else
    bcast = 1'b0;
`endif
    match = '0;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      match[i] = bcast || (col_id[i] == col_tag);
    end
  end

  // Aggregate ready: blocked only by a matched column that is already full.
  always_comb begin
    ready_out = 1'b1;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      if (match[i] && (count_q[i] == FULL_CNT)) ready_out = 1'b0;
    end
    accept = enable_in && ready_out;
  end

  // Per-column push/pop, pointer and occupancy next-state, head-word outputs.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      push[i]       = accept && match[i];
      pop[i]        = (count_q[i] != '0) && ready_in[i];
      wr_ptr_d[i]   = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]    = count_q[i];
      if (push[i] && !pop[i]) count_d[i] = count_q[i] + CW'(1);
      if (!push[i] && pop[i]) count_d[i] = count_q[i] - CW'(1);
      enable_out[i] = (count_q[i] != '0);
      data_out[i]   = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Saturating count of accepted words that matched no column.
  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && (match == '0) && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
    end
  end

  assign drop_count = drop_count_q;

  // Control state: pointers, counts and drop counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_COLS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      drop_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OF_COLS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      drop_count_q <= drop_count_d;
    end
  end

  // FIFO storage: no reset needed, reset pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

endmodule

// File: tb/tb_gin_xbus_fifo.sv
// Bench for gin_xbus_fifo: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_gin_xbus_fifo;
  localparam int DW    = 64;
  localparam int CTW   = 4;
  localparam int NC    = 14;
  localparam int DEPTH = 4;
  localparam int DCW   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [CTW-1:0]  col_tag = '0;
  logic [CTW-1:0]  col_id [0:NC-1];
  logic [DW-1:0]   data_in = '0;
  logic            enable_in = 1'b0;
  logic            ready_out;
  logic [DW-1:0]   data_out [0:NC-1];
  logic [0:NC-1]   enable_out;
  logic [0:NC-1]   ready_in = '0;
  logic [DCW-1:0]  drop_count;

  gin_xbus_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .col_tag    (col_tag),
    .col_id     (col_id),
    .data_in    (data_in),
    .enable_in  (enable_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .enable_out (enable_out),
    .ready_in   (ready_in),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q [NC][$];
  int unsigned   drops = 0;
  logic          exp_ready;
  logic [0:NC-1] mt;
  logic [0:NC-1] exp_en;
  bit            any_match;

  // Compare outputs mid-cycle, then advance the model to what the next edge does.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) exp_q[i].delete();
      drops = 0;
    end else begin
      exp_ready = 1'b1;
      for (int i = 0; i < NC; i++) begin
`ifdef GIN_XBUS_BCAST_EN
        mt[i] = (col_tag == 4'hF) || (col_id[i] == col_tag);
`else
        mt[i] = (col_id[i] == col_tag);
`endif
        if (mt[i] && exp_q[i].size() >= DEPTH) exp_ready = 1'b0;
        exp_en[i] = (exp_q[i].size() > 0);
      end
      chk("ready_out", DW'(ready_out), DW'(exp_ready));
      chk("enable_out", DW'(enable_out), DW'(exp_en));
      chk("drop_count", DW'(drop_count), DW'(drops));
      for (int i = 0; i < NC; i++) begin
        if (exp_en[i]) chk($sformatf("data_out[%0d]", i), data_out[i], exp_q[i][0]);
      end
      for (int i = 0; i < NC; i++) begin
        if (exp_en[i] && ready_in[i]) void'(exp_q[i].pop_front());
      end
      if (enable_in && exp_ready) begin
        any_match = 0;
        for (int i = 0; i < NC; i++) begin
          if (mt[i]) begin
            exp_q[i].push_back(data_in);
            any_match = 1;
          end
        end
        if (!any_match && drops < 32'h0000_FFFF) drops++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; enable_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic ids_identity();
    for (int i = 0; i < NC; i++) col_id[i] = CTW'(i);
  endtask

  // Present one word and hold it until accepted (bounded wait).
  task automatic send(input logic [CTW-1:0] tag, input logic [DW-1:0] d);
    int w;
    w = 0;
    enable_in = 1'b1; col_tag = tag; data_in = d;
    @(negedge clk);
    while (!ready_out && w < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    if (!ready_out) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: tag %0h word %0h not accepted within %0d cycles", tag, d, w);
    end
    @(posedge clk); #1;
    enable_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ids_identity();
    for (int i = 0; i < NC; i++) col_id[i] = CTW'(i);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    chk("reset_enable_out", DW'(enable_out), '0);
    chk("reset_ready_out", DW'(ready_out), DW'(1));
    chk("reset_drop_count", DW'(drop_count), '0);

    // Single word to column 3.
    ready_in = '0;
    send(4'd3, 64'hA5);
    chk("single_enable_out", DW'(enable_out), DW'(14'b0001_0000_0000_00));
    chk("single_data_out3", data_out[3], 64'hA5);
    chk("single_drop", DW'(drop_count), '0);

    // Multicast to columns 2 and 5, column 5 stalled.
    do_reset();
    ids_identity();
    col_id[2] = 4'd7; col_id[5] = 4'd7; col_id[7] = 4'd2;
    ready_in = '1; ready_in[5] = 1'b0;
    for (int k = 0; k < 4; k++) send(4'd7, DW'(32'h200 + k));
    enable_in = 1'b1; col_tag = 4'd7; data_in = 64'h204;
    @(negedge clk);
    chk("mcast_stall_ready", DW'(ready_out), '0);
    chk("mcast_col5_head", data_out[5], 64'h200);
    @(posedge clk); #1;
    ready_in[5] = 1'b1;
    send(4'd7, 64'h204);
    idle(8);
    chk("mcast_drained", DW'(enable_out), '0);

    // Column 4 full: tag 9 passes, tag 4 stalls.
    do_reset();
    ids_identity();
    ready_in = '1; ready_in[4] = 1'b0;
    for (int k = 0; k < 4; k++) send(4'd4, DW'(32'h400 + k));
    enable_in = 1'b1; col_tag = 4'd9; data_in = 64'h309;
    @(negedge clk);
    chk("indep_tag9_ready", DW'(ready_out), DW'(1));
    @(posedge clk); #1;
    col_tag = 4'd4; data_in = 64'h404;
    @(negedge clk);
    chk("indep_tag4_stall", DW'(ready_out), '0);
    @(posedge clk); #1;
    enable_in = 1'b1; col_tag = 4'd9; data_in = 64'h30A;
    @(negedge clk);
    chk("indep_tag9_again", DW'(ready_out), DW'(1));
    @(posedge clk); #1;
    ready_in[4] = 1'b1;
    send(4'd4, 64'h404);
    idle(8);

    // Tag 15 with no column 15.
    do_reset();
    ids_identity();
    ready_in = '0;
    for (int k = 1; k <= 3; k++) begin
      send(4'hF, DW'(32'h500 + k));
`ifdef GIN_XBUS_BCAST_EN
      chk("bcast_enable_out", DW'(enable_out), DW'(14'h3FFF));
      chk("bcast_drop", DW'(drop_count), '0);
`else
      chk("drop_count_step", DW'(drop_count), DW'(k));
`endif
    end

    // Count held at 3 with push and pop every cycle for 20 cycles.
    do_reset();
    ids_identity();
    ready_in = '0;
    for (int k = 0; k < 3; k++) send(4'd0, DW'(100 + k));
    ready_in[0] = 1'b1; enable_in = 1'b1; col_tag = 4'd0;
    for (int k = 3; k < 23; k++) begin
      data_in = DW'(100 + k);
      @(negedge clk);
      chk("stream_ready", DW'(ready_out), DW'(1));
      chk("stream_head", data_out[0], DW'(100 + k - 3));
      @(posedge clk); #1;
    end
    enable_in = 1'b0; ready_in[0] = 1'b0;
    chk("wrap_head", data_out[0], DW'(120));
    chk("wrap_valid", DW'(enable_out[0]), DW'(1));

    // Reset with words buffered and an accept in flight.
    do_reset();
    ids_identity();
    ready_in = '0;
    send(4'd0, 64'h600);
    send(4'd0, 64'h601);
    reset = 1'b1; enable_in = 1'b1; col_tag = 4'd0; data_in = 64'h602;
    @(posedge clk); #1;
    reset = 1'b0; enable_in = 1'b0;
    chk("rst_enable_out", DW'(enable_out), '0);
    chk("rst_drop", DW'(drop_count), '0);
    chk("rst_ready", DW'(ready_out), DW'(1));

    // Random traffic with shuffled (possibly duplicated) column IDs.
    do_reset();
    for (int i = 0; i < NC; i++) col_id[i] = CTW'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      enable_in = ($urandom_range(0, 3) != 0);
      col_tag   = CTW'($urandom_range(0, 15));
      data_in   = {$urandom, $urandom};
      for (int i = 0; i < NC; i++) ready_in[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    enable_in = 1'b0; ready_in = '1;
    idle(10);
    chk("final_empty", DW'(enable_out), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
